// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 block front-end.
package sha256_pkg;

   localparam int         BLOCK_BYTES = 64;
   localparam int         LEN_OFS     = 56;
   localparam logic [7:0] PAD_BYTE    = 8'h80;

   typedef logic [511:0] block_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      ISSUE,
      WAIT,
      LENBLK,
      DONE
   } ctrl_state_t;

   // PAD_TAIL keeps data up to the last byte; PAD_LEN builds the extra length-only block
   typedef enum logic {
      PAD_TAIL,
      PAD_LEN
   } pad_mode_t;

endpackage

// File: rtl/sha256_pad.sv
// Combinational padder: marks the message end with 0x80, zeroes the tail and
// places the big-endian bit length in bytes 56..63 when it fits.
module sha256_pad
   import sha256_pkg::*;
(
   input  block_t      blk_buf,
   input  logic [5:0]  last_pos,
   input  logic [63:0] bit_len,
   input  pad_mode_t   mode,
   output block_t      blk_out
);

   logic len_en;

   always_comb begin
      len_en  = (mode == PAD_LEN) || (int'(last_pos) + 1 <= LEN_OFS - 1);
      blk_out = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         if (mode == PAD_TAIL) begin
            if (i <= int'(last_pos))
               blk_out[511 - 8*i -: 8] = blk_buf[511 - 8*i -: 8];
            else if (i == int'(last_pos) + 1)
               blk_out[511 - 8*i -: 8] = PAD_BYTE;
         end else if (i == 0 && last_pos == 6'd63) begin
            // a message ending on byte 63 had no room for the marker
            blk_out[511 - 8*i -: 8] = PAD_BYTE;
         end
         if (len_en && i >= LEN_OFS)
            blk_out[511 - 8*i -: 8] = bit_len[63 - 8*(i - LEN_OFS) -: 8];
      end
   end

endmodule

// File: rtl/sha256_blk_ctrl.sv
// Byte-stream to 512-bit block sequencer for the sha256 core, with padding and length.
// Optional SHA256_BLK_CTRL_STATS_EN adds a wrapping count of issued blocks.
//
// state  | meaning
// IDLE   | one cycle after reset before accepting bytes
// FILL   | accepting message bytes into the block buffer
// PAD    | apply 0x80 marker / zero tail / length to the final data block
// ISSUE  | block offered to core, held until blk_ready
// WAIT   | core compressing, waiting for core_done
// LENBLK | build the extra block carrying only the length
// DONE   | msg_done pulse, rearm for the next message
module sha256_blk_ctrl
   import sha256_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_first,
   output logic         blk_last,
   input  logic         core_done,
   output logic         msg_done,
   output logic [31:0]  blk_count
);

   ctrl_state_t      state_q, state_d;
   block_t           buf_q, buf_d;
   logic [5:0]       ptr_q, ptr_d;
   logic [5:0]       last_pos_q, last_pos_d;
   logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
   logic             first_q, first_d;
   logic             pend_len_q, pend_len_d;
   logic             blk_first_q, blk_first_d;
   logic             blk_last_q, blk_last_d;
   block_t           pad_out;
   pad_mode_t        pad_mode;

   assign pad_mode = (state_q == LENBLK) ? PAD_LEN : PAD_TAIL;

   sha256_pad u_pad (
      .blk_buf  (buf_q),
      .last_pos (last_pos_q),
      .bit_len  (64'(bitcnt_q)),
      .mode     (pad_mode),
      .blk_out  (pad_out)
   );

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      ptr_d       = ptr_q;
      last_pos_d  = last_pos_q;
      bitcnt_d    = bitcnt_q;
      first_d     = first_q;
      pend_len_d  = pend_len_q;
      blk_first_d = blk_first_q;
      blk_last_d  = blk_last_q;
      case (state_q)
         IDLE: state_d = FILL;
         FILL: begin
            if (in_valid) begin
               buf_d[511 - 8*int'(ptr_q) -: 8] = in_data;
               bitcnt_d = bitcnt_q + LEN_W'(8);
               ptr_d    = ptr_q + 6'd1;
               if (in_last) begin
                  last_pos_d = ptr_q;
                  ptr_d      = '0;
                  state_d    = PAD;
               end else if (ptr_q == 6'd63) begin
                  blk_first_d = first_q;
                  blk_last_d  = 1'b0;
                  pend_len_d  = 1'b0;
                  state_d     = ISSUE;
               end
            end
         end
         PAD: begin
            buf_d       = pad_out;
            blk_first_d = first_q;
            // the length only fits if the 0x80 marker lands at or before byte 55
            if (last_pos_q <= 6'd54) begin
               blk_last_d = 1'b1;
               pend_len_d = 1'b0;
            end else begin
               blk_last_d = 1'b0;
               pend_len_d = 1'b1;
            end
            state_d = ISSUE;
         end
         ISSUE: begin
            if (blk_ready) begin
               first_d = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (core_done) begin
               if (pend_len_q)      state_d = LENBLK;
               else if (blk_last_q) state_d = DONE;
               else                 state_d = FILL;
            end
         end
         LENBLK: begin
            buf_d       = pad_out;
            pend_len_d  = 1'b0;
            blk_first_d = first_q;
            blk_last_d  = 1'b1;
            state_d     = ISSUE;
         end
         DONE: begin
            bitcnt_d = '0;
            first_d  = 1'b1;
            ptr_d    = '0;
            state_d  = FILL;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         ptr_q       <= '0;
         last_pos_q  <= '0;
         bitcnt_q    <= '0;
         first_q     <= 1'b1;
         pend_len_q  <= 1'b0;
         blk_first_q <= 1'b0;
         blk_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         ptr_q       <= ptr_d;
         last_pos_q  <= last_pos_d;
         bitcnt_q    <= bitcnt_d;
         first_q     <= first_d;
         pend_len_q  <= pend_len_d;
         blk_first_q <= blk_first_d;
         blk_last_q  <= blk_last_d;
      end
   end

   assign in_ready  = (state_q == FILL);
   assign blk_valid = (state_q == ISSUE);
   assign msg_done  = (state_q == DONE);
   assign blk_data  = buf_q;
   assign blk_first = blk_first_q;
   assign blk_last  = blk_last_q;

`ifdef SHA256_BLK_CTRL_STATS_EN
   logic [31:0] blk_count_q, blk_count_d;

   always_comb begin
      blk_count_d = blk_count_q;
      if (blk_valid && blk_ready) blk_count_d = blk_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) blk_count_q <= '0;
      else         blk_count_q <= blk_count_d;
   end

   assign blk_count = blk_count_q;
`else
   assign blk_count = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_blk_ctrl.sv
// Directed bench for sha256_blk_ctrl: table of messages with hand-built expected blocks,
// plus hand sequences for back-pressure in ISSUE and reset during WAIT.
module tb_sha256_blk_ctrl;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_data = 8'h00;
   logic         in_last = 1'b0;
   logic         blk_valid;
   logic         blk_ready = 1'b0;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         core_done = 1'b0;
   logic         msg_done;
   logic [31:0]  blk_count;

`ifdef SHA256_BLK_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int issued = 0;

   always #5 clk = ~clk;

   sha256_blk_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .core_done (core_done),
      .msg_done  (msg_done),
      .blk_count (blk_count)
   );

   typedef struct {
      int           len;
      logic [7:0]   start;
      int           nblk;
      logic [511:0] blk0;
      logic [511:0] blk1;
      logic         last0;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] seq_bytes(input int n, input logic [7:0] start);
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < n; i++) b[511 - 8*i -: 8] = start + 8'(i);
      return b;
   endfunction

   task automatic set_vec(input int idx, input int len, input logic [7:0] start,
                          input int nblk, input logic [511:0] b0, input logic [511:0] b1,
                          input logic last0);
      vecs[idx].len   = len;
      vecs[idx].start = start;
      vecs[idx].nblk  = nblk;
      vecs[idx].blk0  = b0;
      vecs[idx].blk1  = b1;
      vecs[idx].last0 = last0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ctl"}, 512'({in_ready, blk_valid, blk_first, blk_last, msg_done}), 512'(0));
      chk({nm, "_data"}, blk_data, 512'(0));
      chk({nm, "_count"}, 512'(blk_count), 512'(0));
   endtask

   // Streams one message and serves its blocks: accept immediately, core_done 3 cycles later.
   task automatic run_msg(input int v);
      int   sent = 0;
      int   blk = 0;
      int   cd = -1;
      int   cyc = 0;
      int   md = 0;
      bit   fin = 1'b0;
      logic xfer;
      logic [511:0] eb;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         blk_ready = 1'b0;
         core_done = 1'b0;
         if (cyc > 600) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout: sent %0d blocks %0d required completion", v, sent, blk);
            fin = 1'b1;
            in_valid = 1'b0;
         end else begin
            in_valid = (sent < vecs[v].len);
            in_data  = vecs[v].start + 8'(sent);
            in_last  = (sent == vecs[v].len - 1);
            if (md == 1) begin
               chk($sformatf("v%0d_msg_done_pulse", v), 512'(msg_done), 512'(1));
               md = 2;
            end else if (md == 2) begin
               chk($sformatf("v%0d_msg_done_clear", v), 512'(msg_done), 512'(0));
               chk($sformatf("v%0d_blk_count", v), 512'(blk_count),
                   512'(STATS ? 32'(issued) : 32'd0));
               fin = 1'b1;
            end
            if (cd > 0) cd--;
            else if (cd == 0) begin
               core_done = 1'b1;
               cd = -1;
               if (blk == vecs[v].nblk) md = 1;
            end
            if (blk_valid && !fin) begin
               eb = (blk == 0) ? vecs[v].blk0 : vecs[v].blk1;
               chk($sformatf("v%0d_blk%0d_data", v, blk), blk_data, eb);
               chk($sformatf("v%0d_blk%0d_first", v, blk), 512'(blk_first), 512'(blk == 0));
               chk($sformatf("v%0d_blk%0d_last", v, blk), 512'(blk_last),
                   512'((blk == 0) ? vecs[v].last0 : 1'b1));
               blk_ready = 1'b1;
            end
         end
         xfer = in_valid && in_ready;
         @(posedge clk);
         if (xfer) sent++;
         if (blk_ready) begin
            blk++;
            issued++;
            cd = 2;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      blk_ready = 1'b0;
      core_done = 1'b0;
   endtask

   task automatic send_only(input int v);
      int   sent = 0;
      int   cyc = 0;
      logic xfer;
      while (sent < vecs[v].len && cyc < 200) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b1;
         in_data  = vecs[v].start + 8'(sent);
         in_last  = (sent == vecs[v].len - 1);
         xfer = in_ready;
         @(posedge clk);
         if (xfer) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk($sformatf("send%0d_bytes", v), 512'(sent), 512'(vecs[v].len));
   endtask

   task automatic wait_blk_valid(input string nm);
      int cyc = 0;
      while (!blk_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_blk_valid_seen"}, 512'(blk_valid), 512'(1));
   endtask

   initial begin
      logic [511:0] b;
      logic [511:0] d0;
      logic         f0, l0;
      int           unstable, rdy_seen;

      set_vec(0, 3, 8'h61, 1, {32'h61626380, 416'h0, 64'h18}, '0, 1'b1);
      b = seq_bytes(55, 8'h00);
      b[511 - 8*55 -: 8] = 8'h80;
      b[63:0] = 64'h1B8;
      set_vec(1, 55, 8'h00, 1, b, '0, 1'b1);
      b = seq_bytes(56, 8'h00);
      b[511 - 8*56 -: 8] = 8'h80;
      set_vec(2, 56, 8'h00, 2, b, {448'h0, 64'h1C0}, 1'b0);
      set_vec(3, 64, 8'h00, 2, seq_bytes(64, 8'h00), {8'h80, 440'h0, 64'h200}, 1'b0);
      set_vec(4, 1, 8'hA5, 1, {8'hA5, 8'h80, 432'h0, 64'h8}, '0, 1'b1);

      #12;
      chk_reset_outputs("reset");
      @(negedge clk);
      resetn = 1'b1;

      for (int v = 0; v < 5; v++) run_msg(v);

      // back-pressure: hold blk_ready low for 10 cycles, stray core_done must be ignored
      send_only(0);
      wait_blk_valid("hold");
      d0 = blk_data;
      f0 = blk_first;
      l0 = blk_last;
      chk("hold_data", d0, vecs[0].blk0);
      unstable = 0;
      rdy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         core_done = (i == 4);
         @(negedge clk);
         core_done = 1'b0;
         if (!blk_valid || blk_data !== d0 || blk_first !== f0 || blk_last !== l0) unstable++;
         if (in_ready) rdy_seen++;
      end
      chk("hold_stable_cycles", 512'(unstable), 512'(0));
      chk("hold_in_ready_cycles", 512'(rdy_seen), 512'(0));
      chk("hold_first_last", 512'({f0, l0}), 512'(2'b11));
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      issued++;
      chk("hold_accepted", 512'(blk_valid), 512'(0));
      @(negedge clk);
      @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      chk("hold_msg_done_pulse", 512'(msg_done), 512'(1));
      @(negedge clk);
      chk("hold_msg_done_clear", 512'(msg_done), 512'(0));
      chk("hold_blk_count", 512'(blk_count), 512'(STATS ? 32'(issued) : 32'd0));

      // async reset while the core is working on a block
      send_only(2);
      wait_blk_valid("rst");
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk_reset_outputs("wait_reset");
      issued = 0;
      @(negedge clk);
      resetn = 1'b1;
      run_msg(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
